// File: rtl/in_reg_pkg.sv
// Shared limits and helpers for the input register bank.
package in_reg_pkg;

  localparam int MAX_DEPTH = 4;
  localparam int MAX_WIDTH = 32;

  // Width of a counter that must reach `depth` without wrapping.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/in_reg_stage.sv
// One WIDTH-bit register stage: enable, synchronous clear, async active-low reset.
module in_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // NOTE: next-state logic assigns its default first so no path leaves data_d unassigned (no latch).
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so every stage samples its neighbour's old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/in_reg_bank.sv
// Input register bank: DEPTH-stage capture chain per channel with fill tracking,
// last-stage change pulses and a per-channel combinational bypass.
module in_reg_bank
  import in_reg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 1,
  parameter int FIXHOLD = 0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] A2F,
  input  logic             IQE,
  input  logic             IQR,
  input  logic [WIDTH-1:0] ISEL,
  output logic [WIDTH-1:0] IQZ,
  output logic             IQV,
  output logic [WIDTH-1:0] IQEDGE
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("in_reg_bank: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("in_reg_bank: DEPTH=%0d outside 1..%0d", DEPTH, MAX_DEPTH);
  end
  if (FIXHOLD < 0 || FIXHOLD > 1) begin : g_bad_fixhold
    $error("in_reg_bank: FIXHOLD=%0d outside 0..1", FIXHOLD);
  end

  localparam int              FILL_W = fill_w(DEPTH);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  // chain[0] feeds stage 1; chain[k] is the output of stage k.
  logic [WIDTH-1:0] chain [DEPTH+1];

  // The hold-fix copy is a distinct net so physical design can pad it with
  // delay cells; logically it is the same value and adds no cycle.
  if (FIXHOLD == 1) begin : g_fixhold
    logic [WIDTH-1:0] a2f_hold;
    assign a2f_hold = A2F;
    assign chain[0] = a2f_hold;
  end else begin : g_direct
    assign chain[0] = A2F;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    in_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (IQC),
      .rst_n (QRT),
      .en_i  (IQE),
      .clr_i (IQR),
      .d_i   (chain[k]),
      .q_o   (chain[k+1])
    );
  end

  logic [FILL_W-1:0] fill_q, fill_d;
  logic              iqv_q, iqv_d;
  logic [WIDTH-1:0]  edge_q, edge_d;

  always_comb begin
    fill_d = fill_q;
    iqv_d  = iqv_q;
    edge_d = '0;
    if (IQR) begin
      fill_d = '0;
      iqv_d  = 1'b0;
    end else if (IQE) begin
      if (fill_q != FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
      iqv_d  = (fill_d == FULL);
      // Stage DEPTH is about to take chain[DEPTH-1]; flag the bits that will flip.
      edge_d = chain[DEPTH-1] ^ chain[DEPTH];
    end
  end

  always_ff @(posedge IQC or negedge QRT) begin
    if (!QRT) begin
      fill_q <= '0;
      iqv_q  <= 1'b0;
      edge_q <= '0;
    end else begin
      fill_q <= fill_d;
      iqv_q  <= iqv_d;
      edge_q <= edge_d;
    end
  end

  assign IQZ    = (ISEL & A2F) | (~ISEL & chain[DEPTH]);
  assign IQV    = iqv_q;
  assign IQEDGE = edge_q;

endmodule
